mem_stage: RTL and testbench

//  Memory stage of the 5-stage core. Consumes the execute-stage ALU result: the result is

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage_load_align.sv | 61 ++++++
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the core pipeline: word type, memory-op encoding, memory-stage FSM state.
// Also provides the load/store classification helpers used by the memory stage.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8,
        LR       = 4'd9,
        SC       = 4'd10
    } memop_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    // LR behaves as a word load on the dcache side.
    function automatic logic is_load(memop_t op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) ||
               (op == LHU) || (op == LR);
    endfunction

    // SC behaves as a word store on the dcache side.
    function automatic logic is_store(memop_t op);
        return (op == SB) || (op == SH) || (op == SW) || (op == SC);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of execute-side, dcache-side, snoop and writeback signals of the memory stage.
// slave: the memory stage itself; master: the surrounding core / environment.
interface mem_stage_if;
    import cpu_types_pkg::*;

    logic   ex_valid;
    logic   ex_ready;
    word_t  ex_alu_out;
    word_t  ex_store_data;
    memop_t ex_mem_op;
    logic [4:0] ex_rd;
    logic   ex_wen;

    logic   dmemREN;
    logic   dmemWEN;
    word_t  dmemaddr;
    word_t  dmemstore;
    logic [3:0] dmembyteen;
    logic   dhit;
    word_t  dmemload;

    logic   ccinv;
    word_t  ccsnoopaddr;

    logic   wb_valid;
    word_t  wb_data;
    logic [4:0] wb_rd;
    logic   wb_wen;
    logic   wb_misaligned;

    modport slave (
        input  ex_valid, ex_alu_out, ex_store_data, ex_mem_op, ex_rd, ex_wen,
        input  dhit, dmemload, ccinv, ccsnoopaddr,
        output ex_ready, dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
        output wb_valid, wb_data, wb_rd, wb_wen, wb_misaligned
    );

    modport master (
        output ex_valid, ex_alu_out, ex_store_data, ex_mem_op, ex_rd, ex_wen,
        output dhit, dmemload, ccinv, ccsnoopaddr,
        input  ex_ready, dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
        input  wb_valid, wb_data, wb_rd, wb_wen, wb_misaligned
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational sub-word handling for the memory stage.
// Extracts/extends load data, generates store lanes and byte enables, flags misalignment.
module load_align
    import cpu_types_pkg::*;
(
    input  memop_t     op_i,
    input  logic [1:0] addr_lo_i,
    input  word_t      store_data_i,
    input  word_t      load_word_i,
    output logic       misaligned_o,
    output logic [3:0] byteen_o,
    output word_t      store_lanes_o,
    output word_t      load_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = load_word_i[8*addr_lo_i +: 8];
    assign ld_half = load_word_i[16*addr_lo_i[1] +: 16];

    always_comb begin
        misaligned_o  = 1'b0;
        byteen_o      = 4'b0000;
        store_lanes_o = '0;
        load_data_o   = '0;
        case (op_i)
            LB:      load_data_o = {{24{ld_byte[7]}}, ld_byte};
            LBU:     load_data_o = {24'h0, ld_byte};
            LH: begin
                misaligned_o = addr_lo_i[0];
                load_data_o  = {{16{ld_half[15]}}, ld_half};
            end
            LHU: begin
                misaligned_o = addr_lo_i[0];
                load_data_o  = {16'h0, ld_half};
            end
            LW, LR: begin
                misaligned_o = (addr_lo_i != 2'b00);
                load_data_o  = load_word_i;
            end
            // Narrow stores replicate their data across every lane; byteen picks the live one.
            SB: begin
                byteen_o      = 4'b0001 << addr_lo_i;
                store_lanes_o = {4{store_data_i[7:0]}};
            end
            SH: begin
                misaligned_o  = addr_lo_i[0];
                byteen_o      = 4'b0011 << addr_lo_i;
                store_lanes_o = {2{store_data_i[15:0]}};
            end
            SW, SC: begin
                misaligned_o  = (addr_lo_i != 2'b00);
                byteen_o      = 4'hF;
                store_lanes_o = store_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: dcache request handshake, sub-word alignment, LR/SC reservation tracking,
// and one registered writeback result per accepted op.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int RSV_GRAN = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_stage_if.slave   bus
);

    mem_state_t state_q, state_d;
    memop_t     op_q, op_d;
    word_t      addr_q, addr_d;
    logic [4:0] rd_q, rd_d;
    logic       wen_q, wen_d;

    logic       dmem_ren_q, dmem_ren_d;
    logic       dmem_wen_q, dmem_wen_d;
    word_t      dmem_addr_q, dmem_addr_d;
    word_t      dmem_store_q, dmem_store_d;
    logic [3:0] dmem_byteen_q, dmem_byteen_d;

    logic       wb_valid_q, wb_valid_d;
    word_t      wb_data_q, wb_data_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic       wb_wen_q, wb_wen_d;
    logic       wb_mis_q, wb_mis_d;

    logic       rsv_valid_q, rsv_valid_d;
    word_t      rsv_addr_q, rsv_addr_d;

    memop_t     sel_op;
    logic [1:0] sel_lo;
    logic       al_misaligned;
    logic [3:0] al_byteen;
    word_t      al_store;
    word_t      al_load;

    function automatic logic rsv_match(word_t a, word_t b);
        return (a >> RSV_GRAN) == (b >> RSV_GRAN);
    endfunction

    // In IDLE the aligner looks at the incoming op; in REQ at the latched one for load data.
    assign sel_op = (state_q == IDLE) ? bus.ex_mem_op : op_q;
    assign sel_lo = (state_q == IDLE) ? bus.ex_alu_out[1:0] : addr_q[1:0];

    load_align u_align (
        .op_i          (sel_op),
        .addr_lo_i     (sel_lo),
        .store_data_i  (bus.ex_store_data),
        .load_word_i   (bus.dmemload),
        .misaligned_o  (al_misaligned),
        .byteen_o      (al_byteen),
        .store_lanes_o (al_store),
        .load_data_o   (al_load)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        rd_d          = rd_q;
        wen_d         = wen_q;
        dmem_ren_d    = dmem_ren_q;
        dmem_wen_d    = dmem_wen_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_store_d  = dmem_store_q;
        dmem_byteen_d = dmem_byteen_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_wen_d      = wb_wen_q;
        wb_mis_d      = wb_mis_q;
        rsv_valid_d   = rsv_valid_q;
        rsv_addr_d    = rsv_addr_q;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    op_d     = bus.ex_mem_op;
                    addr_d   = bus.ex_alu_out;
                    rd_d     = bus.ex_rd;
                    wen_d    = bus.ex_wen;
                    wb_rd_d  = bus.ex_rd;
                    wb_mis_d = 1'b0;
                    if (bus.ex_mem_op == MEM_NONE) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.ex_alu_out;
                        wb_wen_d   = bus.ex_wen;
                    end else if (al_misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_wen_d   = 1'b0;
                        wb_mis_d   = 1'b1;
                    end else if ((bus.ex_mem_op == SC) &&
                                 !(rsv_valid_q && rsv_match(rsv_addr_q, bus.ex_alu_out))) begin
                        // Failed SC never reaches the dcache; status 1 goes straight to rd.
                        wb_valid_d = 1'b1;
                        wb_data_d  = 32'd1;
                        wb_wen_d   = bus.ex_wen;
                    end else begin
                        state_d       = REQ;
                        dmem_ren_d    = is_load(bus.ex_mem_op);
                        dmem_wen_d    = is_store(bus.ex_mem_op);
                        dmem_addr_d   = {bus.ex_alu_out[31:2], 2'b00};
                        dmem_store_d  = al_store;
                        dmem_byteen_d = al_byteen;
                    end
                end
            end
            REQ: begin
                if (bus.dhit) begin
                    state_d    = IDLE;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = is_load(op_q) ? al_load : '0;
                    wb_wen_d   = wen_q;
                    wb_mis_d   = 1'b0;
                    if (op_q == LR) begin
                        rsv_valid_d = 1'b1;
                        rsv_addr_d  = addr_q;
                    end else if (op_q == SC) begin
                        rsv_valid_d = 1'b0;
                    end else if (is_store(op_q) && rsv_match(rsv_addr_q, addr_q)) begin
                        rsv_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Checked against the post-LR address so a same-cycle snoop beats a new reservation.
        if (bus.ccinv && rsv_match(rsv_addr_d, bus.ccsnoopaddr)) begin
            rsv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            op_q          <= MEM_NONE;
            addr_q        <= '0;
            rd_q          <= '0;
            wen_q         <= 1'b0;
            dmem_ren_q    <= 1'b0;
            dmem_wen_q    <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_store_q  <= '0;
            dmem_byteen_q <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_wen_q      <= 1'b0;
            wb_mis_q      <= 1'b0;
            rsv_valid_q   <= 1'b0;
            rsv_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            rd_q          <= rd_d;
            wen_q         <= wen_d;
            dmem_ren_q    <= dmem_ren_d;
            dmem_wen_q    <= dmem_wen_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_store_q  <= dmem_store_d;
            dmem_byteen_q <= dmem_byteen_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_wen_q      <= wb_wen_d;
            wb_mis_q      <= wb_mis_d;
            rsv_valid_q   <= rsv_valid_d;
            rsv_addr_q    <= rsv_addr_d;
        end
    end

    assign bus.ex_ready      = (state_q == IDLE);
    assign bus.dmemREN       = dmem_ren_q;
    assign bus.dmemWEN       = dmem_wen_q;
    assign bus.dmemaddr      = dmem_addr_q;
    assign bus.dmemstore     = dmem_store_q;
    assign bus.dmembyteen    = dmem_byteen_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_wen        = wb_wen_q;
    assign bus.wb_misaligned = wb_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback results,
// a negedge monitor pops and compares them whenever wb_valid is presented.
module tb_mem_stage;
    import cpu_types_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
    } exp_t;

    logic clk;
    logic nRST;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    mem_stage_if bus ();

    mem_stage #(.RSV_GRAN(2)) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(logic [31:0] d, logic [4:0] rd, logic w, logic m);
        exp_t e;
        e.data = d; e.rd = rd; e.wen = w; e.mis = m;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nRST && bus.wb_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got wb_valid=1 data=%h, expected no result", bus.wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.wb_data !== e.data || bus.wb_rd !== e.rd ||
                    bus.wb_wen !== e.wen || bus.wb_misaligned !== e.mis) begin
                    fails++;
                    $display("FAIL wb_result: got data=%h rd=%0d wen=%b mis=%b, expected data=%h rd=%0d wen=%b mis=%b",
                             bus.wb_data, bus.wb_rd, bus.wb_wen, bus.wb_misaligned,
                             e.data, e.rd, e.wen, e.mis);
                end
            end
        end
    end

    // Present one op for a single accepted cycle; returns on the negedge after acceptance.
    task automatic send(memop_t op, logic [31:0] a, logic [31:0] sd, logic [4:0] rd, logic w);
        @(negedge clk);
        chk("ex_ready_idle", {31'h0, bus.ex_ready}, 32'd1);
        bus.ex_valid      = 1'b1;
        bus.ex_mem_op     = op;
        bus.ex_alu_out    = a;
        bus.ex_store_data = sd;
        bus.ex_rd         = rd;
        bus.ex_wen        = w;
        @(negedge clk);
        bus.ex_valid = 1'b0;
    endtask

    // Hold the dcache off for n cycles, then complete; optionally snoop in the dhit cycle.
    task automatic serve(int n, logic [31:0] ld, logic wr, logic inv, logic [31:0] inv_a);
        for (int i = 0; i < n; i++) begin
            chk(wr ? "dmemWEN_held" : "dmemREN_held",
                {31'h0, (wr ? bus.dmemWEN : bus.dmemREN)}, 32'd1);
            chk("ex_ready_req", {31'h0, bus.ex_ready}, 32'd0);
            if (i == n - 1) begin
                bus.dhit     = 1'b1;
                bus.dmemload = ld;
                if (inv) begin
                    bus.ccinv       = 1'b1;
                    bus.ccsnoopaddr = inv_a;
                end
            end
            @(negedge clk);
            bus.dhit  = 1'b0;
            bus.ccinv = 1'b0;
        end
        chk("req_dropped", {30'h0, bus.dmemREN, bus.dmemWEN}, 32'd0);
    endtask

    task automatic snoop(logic [31:0] a);
        @(negedge clk);
        bus.ccinv       = 1'b1;
        bus.ccsnoopaddr = a;
        @(negedge clk);
        bus.ccinv = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nRST  = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_mem_op = MEM_NONE; bus.ex_alu_out = '0;
        bus.ex_store_data = '0; bus.ex_rd = '0; bus.ex_wen = 1'b0;
        bus.dhit = 1'b0; bus.dmemload = '0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;

        repeat (2) @(negedge clk);
        chk("rst_wb", {bus.wb_valid, bus.wb_wen, bus.wb_misaligned, bus.wb_rd}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_req", {bus.dmemREN, bus.dmemWEN, bus.dmembyteen}, 32'd0);
        chk("rst_addr", bus.dmemaddr, 32'd0);
        chk("rst_store", bus.dmemstore, 32'd0);
        chk("rst_ready", {31'h0, bus.ex_ready}, 32'd1);
        nRST = 1'b1;

        // Passthrough
        push(32'h1234, 5'd3, 1'b1, 1'b0);
        send(MEM_NONE, 32'h1234, 32'h0, 5'd3, 1'b1);
        chk("none_no_ren", {31'h0, bus.dmemREN}, 32'd0);

        // Sub-word loads
        push(32'hFFFF_FF80, 5'd5, 1'b1, 1'b0);
        send(LB, 32'h103, 32'h0, 5'd5, 1'b1);
        chk("lb_addr", bus.dmemaddr, 32'h100);
        serve(3, 32'h80FF_FFFF, 1'b0, 1'b0, 32'h0);

        push(32'hFFFF_8001, 5'd6, 1'b1, 1'b0);
        send(LH, 32'h102, 32'h0, 5'd6, 1'b1);
        serve(1, 32'h8001_0000, 1'b0, 1'b0, 32'h0);

        push(32'h0000_8001, 5'd7, 1'b1, 1'b0);
        send(LHU, 32'h102, 32'h0, 5'd7, 1'b1);
        serve(2, 32'h8001_0000, 1'b0, 1'b0, 32'h0);

        push(32'h0000_00F0, 5'd8, 1'b1, 1'b0);
        send(LBU, 32'h101, 32'h0, 5'd8, 1'b1);
        serve(1, 32'h0000_F000, 1'b0, 1'b0, 32'h0);

        // Stores
        push(32'h0, 5'd0, 1'b0, 1'b0);
        send(SH, 32'h202, 32'hABCD, 5'd0, 1'b0);
        chk("sh_byteen", {28'h0, bus.dmembyteen}, 32'hC);
        chk("sh_store", bus.dmemstore, 32'hABCD_ABCD);
        chk("sh_addr", bus.dmemaddr, 32'h200);
        chk("sh_no_ren", {31'h0, bus.dmemREN}, 32'd0);
        serve(2, 32'h0, 1'b1, 1'b0, 32'h0);

        push(32'h0, 5'd0, 1'b0, 1'b0);
        send(SB, 32'h301, 32'h1234_5678, 5'd0, 1'b0);
        chk("sb_byteen", {28'h0, bus.dmembyteen}, 32'h2);
        chk("sb_store", bus.dmemstore, 32'h7878_7878);
        serve(1, 32'h0, 1'b1, 1'b0, 32'h0);

        // Misalignment
        push(32'h0, 5'd9, 1'b0, 1'b1);
        send(LW, 32'h101, 32'h0, 5'd9, 1'b1);
        chk("lw_mis_no_req", {30'h0, bus.dmemREN, bus.dmemWEN}, 32'd0);

        push(32'h0, 5'd9, 1'b0, 1'b1);
        send(LH, 32'h103, 32'h0, 5'd9, 1'b1);
        chk("lh_mis_no_req", {30'h0, bus.dmemREN, bus.dmemWEN}, 32'd0);

        // LR then SC succeeds
        push(32'hDEAD_BEEF, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h40, 32'h0, 5'd10, 1'b1);
        serve(1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        push(32'h0, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h5, 5'd11, 1'b1);
        chk("sc_byteen", {28'h0, bus.dmembyteen}, 32'hF);
        chk("sc_store", bus.dmemstore, 32'h5);
        serve(1, 32'h0, 1'b1, 1'b0, 32'h0);

        // Second SC after the first consumed the reservation fails
        push(32'h1, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h5, 5'd11, 1'b1);
        chk("sc_reuse_no_wen", {31'h0, bus.dmemWEN}, 32'd0);

        // Snoop to a different word leaves the reservation intact
        push(32'h0000_0001, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h40, 32'h0, 5'd10, 1'b1);
        serve(1, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
        snoop(32'h44);
        push(32'h0, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h7, 5'd11, 1'b1);
        serve(1, 32'h0, 1'b1, 1'b0, 32'h0);

        // Snoop to the reserved word kills the SC
        push(32'h2, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h40, 32'h0, 5'd10, 1'b1);
        serve(1, 32'h2, 1'b0, 1'b0, 32'h0);
        snoop(32'h42);
        push(32'h1, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h7, 5'd11, 1'b1);
        chk("sc_inv_no_wen", {31'h0, bus.dmemWEN}, 32'd0);

        // Snoop in the same cycle as the LR completion wins
        push(32'h3, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h40, 32'h0, 5'd10, 1'b1);
        serve(1, 32'h3, 1'b0, 1'b1, 32'h40);
        push(32'h1, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h7, 5'd11, 1'b1);
        chk("sc_race_no_wen", {31'h0, bus.dmemWEN}, 32'd0);

        // Snoop while the SC is already in flight: SC still succeeds
        push(32'h4, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h40, 32'h0, 5'd10, 1'b1);
        serve(1, 32'h4, 1'b0, 1'b0, 32'h0);
        push(32'h0, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h7, 5'd11, 1'b1);
        serve(2, 32'h0, 1'b1, 1'b1, 32'h40);

        // Own store to the reserved word clears it
        push(32'h5, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h80, 32'h0, 5'd10, 1'b1);
        serve(1, 32'h5, 1'b0, 1'b0, 32'h0);
        push(32'h0, 5'd0, 1'b0, 1'b0);
        send(SW, 32'h80, 32'h99, 5'd0, 1'b0);
        serve(1, 32'h0, 1'b1, 1'b0, 32'h0);
        push(32'h1, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h80, 32'h7, 5'd11, 1'b1);
        chk("sc_own_store_no_wen", {31'h0, bus.dmemWEN}, 32'd0);

        // Reset in the middle of a request drops it at once and clears the reservation
        push(32'h6, 5'd10, 1'b1, 1'b0);
        send(LR, 32'h40, 32'h0, 5'd10, 1'b1);
        serve(1, 32'h6, 1'b0, 1'b0, 32'h0);
        send(LW, 32'h10, 32'h0, 5'd12, 1'b1);
        chk("rst_pre_ren", {31'h0, bus.dmemREN}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_mid_ren", {31'h0, bus.dmemREN}, 32'd0);
        chk("rst_mid_wb", {31'h0, bus.wb_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        push(32'h1, 5'd11, 1'b1, 1'b0);
        send(SC, 32'h40, 32'h7, 5'd11, 1'b1);
        chk("sc_after_rst_no_wen", {31'h0, bus.dmemWEN}, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
